// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage.
// Op codes, flag bit positions and FSM state encoding.
package exec_pkg;

  localparam int WORD = 16;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_CMP = 4'd5,
    OP_MOV = 4'd6,
    OP_SLL = 4'd8,
    OP_SLR = 4'd9,
    OP_SRL = 4'd10,
    OP_SRA = 4'd11,
    OP_MUL = 4'd12
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MULB = 1'b1
  } state_t;

endpackage

// File: rtl/exec_stage_mul_iter.sv
// Iterative shift-add multiplier, one partial product per clock.
// Present only when EXEC_MUL_EN is defined.
`ifdef EXEC_MUL_EN
module mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // The start edge already folds in bit 0, so the last bit
  // lands WIDTH-1 edges later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
      cnt    <= CW'(1);
    end else if (cnt != '0 && cnt != CW'(WIDTH)) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign done       = (cnt == CW'(WIDTH));
  assign prod_lo    = acc[WIDTH-1:0];
  assign prod_hi_nz = |acc[2*WIDTH-1:WIDTH];

endmodule
`endif

// File: rtl/exec_stage.sv
// Execute stage: ALU/shifter, S/Z/C/V flags, regfile write port.
// Define EXEC_MUL_EN to add the multi-cycle multiplier (MUL op).
module exec_stage
  import exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RADDR = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  input  logic [3:0]       shamt,
  input  logic [RADDR-1:0] dst,
  output logic             out_we,
  output logic [RADDR-1:0] out_wr,
  output logic [WIDTH-1:0] out_wd,
  output logic [3:0]       flags
);

  op_t opc;
  logic accept;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [WIDTH:0]     shl;
  logic [WIDTH:0]     shr;
  logic [WIDTH:0]     sra;
  logic [2*WIDTH-1:0] rot;

  logic [WIDTH-1:0] res;
  logic             c_n;
  logic             v_n;
  logic             wr_n;
  logic             upd_n;
  logic [3:0]       fl_n;

  assign opc    = op_t'(op);
  assign accept = in_valid && in_ready;

  assign sum = {1'b0, ra} + {1'b0, rb};
  assign dif = {1'b0, ra} - {1'b0, rb};

  // Extra bit on each shift catches the last bit shifted out.
  assign shl = {1'b0, ra} << shamt;
  assign shr = {ra, 1'b0} >> shamt;
  assign sra = $signed({ra, 1'b0}) >>> shamt;
  assign rot = {ra, ra} << shamt;

  always_comb begin
    res   = '0;
    c_n   = 1'b0;
    v_n   = 1'b0;
    wr_n  = 1'b0;
    upd_n = 1'b0;
    case (opc)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        c_n   = sum[WIDTH];
        v_n   = (ra[WIDTH-1] == rb[WIDTH-1])
             && (sum[WIDTH-1] != ra[WIDTH-1]);
        wr_n  = 1'b1;
        upd_n = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        res   = dif[WIDTH-1:0];
        c_n   = dif[WIDTH];
        v_n   = (ra[WIDTH-1] != rb[WIDTH-1])
             && (dif[WIDTH-1] != ra[WIDTH-1]);
        wr_n  = (opc == OP_SUB);
        upd_n = 1'b1;
      end
      OP_AND: begin
        res   = ra & rb;
        wr_n  = 1'b1;
        upd_n = 1'b1;
      end
      OP_OR: begin
        res   = ra | rb;
        wr_n  = 1'b1;
        upd_n = 1'b1;
      end
      OP_XOR: begin
        res   = ra ^ rb;
        wr_n  = 1'b1;
        upd_n = 1'b1;
      end
      OP_MOV: begin
        res   = rb;
        wr_n  = 1'b1;
        upd_n = 1'b1;
      end
      OP_SLL: begin
        res   = shl[WIDTH-1:0];
        c_n   = shl[WIDTH];
        wr_n  = 1'b1;
        upd_n = 1'b1;
      end
      OP_SLR: begin
        res   = rot[2*WIDTH-1:WIDTH];
        c_n   = (shamt != 4'd0) && rot[WIDTH];
        wr_n  = 1'b1;
        upd_n = 1'b1;
      end
      OP_SRL: begin
        res   = shr[WIDTH:1];
        c_n   = shr[0];
        wr_n  = 1'b1;
        upd_n = 1'b1;
      end
      OP_SRA: begin
        res   = sra[WIDTH:1];
        c_n   = sra[0];
        wr_n  = 1'b1;
        upd_n = 1'b1;
      end
      default: ;
    endcase
  end

  assign fl_n = {res[WIDTH-1], res == '0, c_n, v_n};

`ifdef EXEC_MUL_EN
  state_t state;
  logic [$clog2(WIDTH)-1:0] cnt;
  logic [RADDR-1:0] dst_q;
  logic mul_go;
  logic done;
  logic [WIDTH-1:0] prod_lo;
  logic prod_hi_nz;

  assign mul_go   = accept && (opc == OP_MUL);
  assign in_ready = (state == IDLE);

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk        (clk),
    .reset      (reset),
    .start      (mul_go),
    .a          (ra),
    .b          (rb),
    .done       (done),
    .prod_lo    (prod_lo),
    .prod_hi_nz (prod_hi_nz)
  );
`else
  assign in_ready = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_we <= 1'b0;
      out_wr <= '0;
      out_wd <= '0;
      flags  <= '0;
`ifdef EXEC_MUL_EN
      state  <= IDLE;
      cnt    <= '0;
      dst_q  <= '0;
`endif
    end else begin
      out_we <= accept && wr_n;
      if (accept && wr_n) begin
        out_wr <= dst;
        out_wd <= res;
      end
      if (accept && upd_n) begin
        flags <= fl_n;
      end
`ifdef EXEC_MUL_EN
      unique case (state)
        IDLE: begin
          if (mul_go) begin
            state <= MULB;
            cnt   <= '0;
            dst_q <= dst;
          end
        end
        MULB: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state  <= IDLE;
            out_we <= done;
            out_wr <= dst_q;
            out_wd <= prod_lo;
            flags  <= {prod_lo[WIDTH-1], prod_lo == '0,
                       prod_hi_nz, 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Directed self-checking bench for exec_stage.
// Follows EXEC_MUL_EN to pick the expected MUL behaviour.
module tb_exec_stage;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [15:0] ra = 16'd0;
  logic [15:0] rb = 16'd0;
  logic [3:0]  shamt = 4'd0;
  logic [2:0]  dst = 3'd0;
  logic        out_we;
  logic [2:0]  out_wr;
  logic [15:0] out_wd;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  int cnt;

  always #5 clk = ~clk;

  exec_stage #(.WIDTH(16), .RADDR(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .ra       (ra),
    .rb       (rb),
    .shamt    (shamt),
    .dst      (dst),
    .out_we   (out_we),
    .out_wr   (out_wr),
    .out_wd   (out_wd),
    .flags    (flags)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [3:0] s,
                       input logic [2:0] d);
    in_valid = 1'b1;
    op = o;
    ra = a;
    rb = b;
    shamt = s;
    dst = d;
  endtask

  initial begin
    repeat (2) tick;
    reset = 1'b0;
    tick;
    chk("rst_we", 32'(out_we), 32'd0);
    chk("rst_wr", 32'(out_wr), 32'd0);
    chk("rst_wd", 32'(out_wd), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    drive(OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 3'd3);
    tick;
    chk("add_we", 32'(out_we), 32'd1);
    chk("add_wr", 32'(out_wr), 32'd3);
    chk("add_wd", 32'(out_wd), 32'h8000);
    chk("add_flags", 32'(flags), 32'b1001);

    drive(OP_CMP, 16'h0005, 16'h0005, 4'd0, 3'd6);
    tick;
    chk("cmp_we", 32'(out_we), 32'd0);
    chk("cmp_flags", 32'(flags), 32'b0100);

    drive(OP_SUB, 16'h0000, 16'h0001, 4'd0, 3'd1);
    tick;
    chk("sub_we", 32'(out_we), 32'd1);
    chk("sub_wr", 32'(out_wr), 32'd1);
    chk("sub_wd", 32'(out_wd), 32'hFFFF);
    chk("sub_flags", 32'(flags), 32'b1010);

    drive(OP_SRA, 16'h8001, 16'h0000, 4'd1, 3'd7);
    tick;
    chk("sra_wr", 32'(out_wr), 32'd7);
    chk("sra_wd", 32'(out_wd), 32'hC000);
    chk("sra_flags", 32'(flags), 32'b1010);

    drive(OP_SLR, 16'h8001, 16'h0000, 4'd1, 3'd5);
    tick;
    chk("slr_wd", 32'(out_wd), 32'h0003);
    chk("slr_flags", 32'(flags), 32'b0010);

    drive(OP_SLL, 16'h1234, 16'h0000, 4'd0, 3'd4);
    tick;
    chk("sll0_wd", 32'(out_wd), 32'h1234);
    chk("sll0_flags", 32'(flags), 32'b0000);

    drive(OP_SRL, 16'h0003, 16'h0000, 4'd2, 3'd4);
    tick;
    chk("srl_wd", 32'(out_wd), 32'h0000);
    chk("srl_flags", 32'(flags), 32'b0110);

    drive(OP_XOR, 16'hFF00, 16'h0FF0, 4'd0, 3'd6);
    tick;
    chk("xor_wd", 32'(out_wd), 32'hF0F0);
    chk("xor_flags", 32'(flags), 32'b1000);

    drive(4'd7, 16'h0000, 16'h0000, 4'd0, 3'd2);
    tick;
    chk("nop_we", 32'(out_we), 32'd0);
    chk("nop_flags", 32'(flags), 32'b1000);

    in_valid = 1'b0;
    tick;
    chk("idle_we", 32'(out_we), 32'd0);

    drive(OP_MUL, 16'h0100, 16'h0101, 4'd0, 3'd2);
    tick;
`ifdef EXEC_MUL_EN
    drive(OP_ADD, 16'h0001, 16'h0001, 4'd0, 3'd6);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (!in_ready && !out_we) cnt++;
      tick;
    end
    chk("mul_busy", 32'(cnt), 32'd16);
    chk("mul_we", 32'(out_we), 32'd1);
    chk("mul_wr", 32'(out_wr), 32'd2);
    chk("mul_wd", 32'(out_wd), 32'h0100);
    chk("mul_flags", 32'(flags), 32'b0010);
    chk("mul_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    tick;
    chk("mul_we_pulse", 32'(out_we), 32'd0);
`else
    chk("mul_we", 32'(out_we), 32'd0);
    chk("mul_flags", 32'(flags), 32'b1000);
    chk("mul_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (out_we) cnt++;
    end
    chk("mul_nowrite", 32'(cnt), 32'd0);
`endif

    drive(OP_MUL, 16'h00FF, 16'h0003, 4'd0, 3'd5);
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    reset = 1'b1;
    #1;
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_we", 32'(out_we), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    tick;
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (out_we) cnt++;
    end
    chk("abort_nowrite", 32'(cnt), 32'd0);

    drive(OP_ADD, 16'h0001, 16'h0001, 4'd0, 3'd0);
    tick;
    chk("post_we", 32'(out_we), 32'd1);
    chk("post_wr", 32'(out_wr), 32'd0);
    chk("post_wd", 32'(out_wd), 32'h0002);
    chk("post_flags", 32'(flags), 32'b0000);
    in_valid = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
